sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation (binary-search) controller that drives the `a` operand of the team's N-bit magnitude comparator. It consumes that comparator's smaller/equal/bigger flags to locate an unknown target value on the `b` operand.
- The target is held externally (register, DAC threshold, lookup key). This block only generates guesses and interprets the three flags.
- Used for threshold finding and for sorted-key search in later designs.

Parameters:
- N, 8, operand width. The search range is 0 to 2^N-1.
- STEP_W is a localparam, not overridable, equal to $clog2(N+2). It is the width of the probe counter and covers up to N+1 probes.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous and active-high. Only one clock is used.
- start  input  1  begin a search. Sampled only in IDLE.
- smaller  input  1  comparator flag: guess < target.
- equal  input  1  comparator flag: guess == target.
- bigger  input  1  comparator flag: guess > target.
- guess  output  N  registered probe value, wired to the comparator `a` input.
- busy  output  1  high in SEARCH.
- done  output  1  one-cycle pulse when a search ends.
- found  output  1  the last search hit equal. Valid from done until the next start.
- err  output  1  the last search aborted on invalid flags. Valid from done until the next start.
- result  output  N  matching value if found, else the last guess. Held until the next start.
- steps  output  STEP_W  number of comparisons used by the last search. Held until the next start.

Behaviour:
- Reset (synchronous, rst high at a clk edge): state returns to IDLE. guess, result, steps, lo and hi all clear to 0. busy, done, found and err clear to 0. Reset mid-search aborts with no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE with start=1:
  - set lo=0, hi=2^N-1, guess=2^(N-1)-1.
  - clear steps, found and err.
  - go to SEARCH. busy rises on the next cycle.
- SEARCH, every cycle:
  - The flags are combinational from the current guess and are sampled at the edge. steps increments by 1.
  - equal only: found=1, result=guess, go to DONE.
  - smaller only, guess==2^N-1: found=0, result=guess, go to DONE (exhausted).
  - smaller only, otherwise: lo=guess+1.
  - bigger only, guess==0: found=0, result=guess, go to DONE (exhausted).
  - bigger only, otherwise: hi=guess-1.
  - If the updated lo > hi: found=0, result=guess, go to DONE.
  - Else: guess = lo + ((hi-lo)>>1), computed from the updated lo/hi with N+1-bit intermediate width, floor rounding.
  - Flags not exactly one-hot (zero or more than one set): err=1, found=0, result=guess, go to DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE. guess holds its last value.
- start is ignored in SEARCH and DONE. A start in IDLE on the cycle after DONE is accepted.
- Latency: one cycle from start to the first probe. There is one probe per cycle. Maximum probes is N+1; for N=8, target 255 needs 9.
- lo and hi are internal N-bit registers. The boundary checks above guarantee they never wrap.

Test Plan:
- Ideal comparator model, N=8, target=127, pulse start -> one probe (guess 127), done the next cycle, found=1, result=127, steps=1, err=0.
- target=255 -> guess sequence 127, 191, 223, 239, 247, 251, 253, 254, 255; found=1, steps=9.
- target=0 -> guess sequence 127, 63, 31, 15, 7, 3, 1, 0; found=1, steps=8. Also sweep all 256 targets: found=1, result==target and steps<=9 for every one.
- Model that always returns smaller (out-of-range target) -> ends at guess=255 with found=0, err=0, steps=9, done pulsed once.
- Force all flags 0 on the third probe -> err=1, found=0, result=31 (probes 127, 63, 31 against target 20), steps=3.
- Assert rst mid-search (after probe 2) -> next cycle all outputs are 0, state IDLE, no done. A start pulsed during busy in a separate run has no effect on that run's guess sequence.

Source files
------------

// File: rtl/sar_search_if.sv
// sar_search_if: probe/flag/result bundle between the search controller and its environment
interface sar_search_if #(parameter int N = 8);
  localparam int STEP_W = $clog2(N + 2);
  logic start;
  logic smaller;
  logic equal;
  logic bigger;
  logic [N-1:0] guess;
  logic busy;
  logic done;
  logic found;
  logic err;
  logic [N-1:0] result;
  logic [STEP_W-1:0] steps;
  modport master (
    input  start, smaller, equal, bigger,
    output guess, busy, done, found, err, result, steps
  );
  modport slave (
    output start, smaller, equal, bigger,
    input  guess, busy, done, found, err, result, steps
  );
endinterface

// File: rtl/sar_search.sv
// sar_search: binary-search controller probing an external comparator to locate its b operand
module sar_search #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  sar_search_if.master bus
);
  localparam int STEP_W = $clog2(N + 2);
  localparam logic [N-1:0] MAX = '1;
  localparam logic [N-1:0] FIRST = {1'b0, {(N-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state_q;
  logic [N-1:0] lo_q, hi_q, guess_q, result_q;
  logic [STEP_W-1:0] steps_q;
  logic busy_q, done_q, found_q, err_q;
  logic [N-1:0] lo_d, hi_d, guess_d;
  logic [N:0] mid;
  logic onehot, stop;
  always_comb begin
    onehot = {bus.smaller, bus.equal, bus.bigger} inside {3'b100, 3'b010, 3'b001};
    lo_d = bus.smaller ? guess_q + 1'b1 : lo_q;
    hi_d = bus.bigger ? guess_q - 1'b1 : hi_q;
    // widened midpoint so lo + half-span cannot overflow
    mid = {1'b0, lo_d} + (({1'b0, hi_d} - {1'b0, lo_d}) >> 1);
    guess_d = mid[N-1:0];
    stop = !onehot || bus.equal || (bus.smaller && guess_q == MAX) ||
           (bus.bigger && guess_q == '0) || lo_d > hi_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      guess_q <= '0;
      result_q <= '0;
      steps_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      found_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= SEARCH;
          lo_q <= '0;
          hi_q <= MAX;
          guess_q <= FIRST;
          steps_q <= '0;
          found_q <= 1'b0;
          err_q <= 1'b0;
          busy_q <= 1'b1;
        end
        SEARCH: begin
          steps_q <= steps_q + 1'b1;
          if (stop) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            found_q <= onehot && bus.equal;
            err_q <= !onehot;
            result_q <= guess_q;
          end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            guess_q <= guess_d;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.guess = guess_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.found = found_q;
  assign bus.err = err_q;
  assign bus.result = result_q;
  assign bus.steps = steps_q;
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: table, sweep and random checks of sar_search against a plain binary-search model
module tb_sar_search;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sar_search_if #(.N(8)) bus ();
  sar_search #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] target = '0;
  bit mode = 1'b0;
  int kill = 0;
  int nprobe = 0;
  int tests = 0;
  int fails = 0;
  int seen[$];
  int mq[$];
  logic kz;
  assign kz = kill != 0 && nprobe == kill;
  assign bus.smaller = !kz && (mode || bus.guess < target);
  assign bus.equal = !kz && !mode && bus.guess == target;
  assign bus.bigger = !kz && !mode && bus.guess > target;
  typedef struct {int t; bit m; int k; bit f; bit e; int r; int s;} vec_t;
  vec_t vt[5];
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic check_seq(input string name, input int exp[$]);
    int bad = -1;
    tests++;
    if (seen.size() != exp.size()) bad = 999;
    else foreach (exp[i]) if (bad < 0 && seen[i] != exp[i]) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: guess sequence differs at %0d (got %0d probes, expected %0d)",
               name, bad, seen.size(), exp.size());
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (bus.busy) begin
      seen.push_back(int'(bus.guess));
      nprobe++;
    end
  endtask
  // plain-integer binary search straight from the search rules
  task automatic model(input int t, input bit m, input int k,
                       output bit f, output bit e, output int r, output int s);
    int lo = 0, hi = 255, g = 127;
    bit sm;
    mq.delete();
    f = 0; e = 0; s = 0;
    forever begin
      s++;
      mq.push_back(g);
      r = g;
      if (k == s) begin e = 1; return; end
      sm = m || g < t;
      if (!m && g == t) begin f = 1; return; end
      if (sm) begin if (g == 255) return; lo = g + 1; end
      else begin if (g == 0) return; hi = g - 1; end
      if (lo > hi) return;
      g = (lo + hi) / 2;
    end
  endtask
  task automatic do_search(input int t, input bit m, input int k, input int sp);
    bit got = 0;
    target = t[7:0]; mode = m; kill = k; nprobe = 0; seen.delete();
    bus.start = 1'b1;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      bus.start = sp != 0 && bus.busy && nprobe == sp;
      if (bus.done) got = 1;
    end
    bus.start = 1'b0;
    check("done_seen", int'(got), 1);
    tick();
    check("done_single", int'(bus.done), 0);
  endtask
  task automatic check_vs_model(input string name, input int t, input bit m, input int k);
    bit f, e;
    int r, s;
    model(t, m, k, f, e, r, s);
    check({name, "_found"}, int'(bus.found), int'(f));
    check({name, "_err"}, int'(bus.err), int'(e));
    check({name, "_result"}, int'(bus.result), r);
    check({name, "_steps"}, int'(bus.steps), s);
    check_seq({name, "_seq"}, mq);
  endtask
  task automatic check_zero(input string name);
    check({name, "_guess"}, int'(bus.guess), 0);
    check({name, "_result"}, int'(bus.result), 0);
    check({name, "_steps"}, int'(bus.steps), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_done"}, int'(bus.done), 0);
    check({name, "_found"}, int'(bus.found), 0);
    check({name, "_err"}, int'(bus.err), 0);
  endtask
  initial begin
    int s255[$] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    int s0[$] = '{127, 63, 31, 15, 7, 3, 1, 0};
    int sall[$] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    int bad;
    vt = '{'{127, 0, 0, 1, 0, 127, 1}, '{255, 0, 0, 1, 0, 255, 9},
           '{0, 0, 0, 1, 0, 0, 8}, '{0, 1, 0, 0, 0, 255, 9},
           '{20, 0, 3, 0, 1, 31, 3}};
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    foreach (vt[i]) begin
      do_search(vt[i].t, vt[i].m, vt[i].k, 0);
      check($sformatf("vec%0d_found", i), int'(bus.found), int'(vt[i].f));
      check($sformatf("vec%0d_err", i), int'(bus.err), int'(vt[i].e));
      check($sformatf("vec%0d_result", i), int'(bus.result), vt[i].r);
      check($sformatf("vec%0d_steps", i), int'(bus.steps), vt[i].s);
      check($sformatf("vec%0d_hold", i), int'(bus.guess), vt[i].r);
      if (i == 1) check_seq("seq255", s255);
      if (i == 2) check_seq("seq0", s0);
      if (i == 3) check_seq("seq_all_smaller", sall);
    end
    bad = 0;
    for (int t = 0; t < 256; t++) begin
      do_search(t, 0, 0, 0);
      if (!bus.found || int'(bus.result) != t || bus.steps > 9 || bus.err) bad++;
      if (t % 37 == 0) check_vs_model($sformatf("sweep%0d", t), t, 0, 0);
    end
    check("sweep_bad_count", bad, 0);
    for (int i = 0; i < 40; i++) begin
      int t = int'($urandom_range(0, 255));
      bit m = 1'($urandom_range(0, 1));
      int k = $urandom_range(0, 1) != 0 ? int'($urandom_range(1, 9)) : 0;
      do_search(t, m, k, 0);
      check_vs_model($sformatf("rand%0d", i), t, m, k);
    end
    target = 8'd0; mode = 0; kill = 0; nprobe = 0; seen.delete();
    bus.start = 1'b1;
    for (int c = 0; c < 10 && nprobe < 2; c++) begin
      tick();
      bus.start = 1'b0;
    end
    check("rst_mid_probes", nprobe, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_mid");
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) bad++;
    end
    check("rst_mid_quiet", bad, 0);
    do_search(255, 0, 0, 3);
    check_seq("start_in_busy_seq", s255);
    check("start_in_busy_steps", int'(bus.steps), 9);
    repeat (3) @(negedge clk);
    check("start_in_busy_idle", int'(bus.busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
